noc_router_wh: RTL
==================

NOC_ROUTER_WH -- requirements
Module: noc_router_wh

Interface
REQ-001 Parameter DATA_W, 16, flit width in bits (min 8).
REQ-002 Parameter FIFO_DEPTH, 4, input FIFO entries per port (power of two, 2..16).
REQ-003 Parameter COORD_W, 3, width of each destination coordinate field.
REQ-004 Parameter XCOORD, 1, this router's X coordinate.
REQ-005 Parameter YCOORD, 1, this router's Y coordinate.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 in_data  in  5*DATA_W  incoming flits; port p occupies bits [p*DATA_W +: DATA_W]; p = 0 N, 1 S, 2 E, 3 W, 4 L.
REQ-009 in_valid  in  5  flit present on port p this cycle.
REQ-010 in_credit  out  5  one-cycle pulse per freed input FIFO entry of port p.
REQ-011 out_data  out  5*DATA_W  outgoing flits, registered.
REQ-012 out_valid  out  5  flit present on out_data port p, registered.
REQ-013 out_credit  in  5  one-cycle pulse: downstream freed one entry for output p.
REQ-014 err_overflow  out  5  sticky: write attempted into a full input FIFO of port p.

Function
REQ-015 Flit type = bits [DATA_W-1:DATA_W-2]: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-016 Head/single flit: dest X = bits [COORD_W-1:0], dest Y = bits [2*COORD_W-1:COORD_W].
REQ-017 XY routing: dX > XCOORD -> E; dX < XCOORD -> W; else dY > YCOORD -> N; dY < YCOORD -> S; else L.
REQ-018 Per input: FIFO of FIFO_DEPTH; push on in_valid when not full; push and pop in same cycle legal at any occupancy, including full.
REQ-019 Push into full FIFO: flit discarded, err_overflow[p] set until reset.
REQ-020 Per output: credit counter, reset to FIFO_DEPTH; decrement on send, increment on out_credit; simultaneous send and credit leaves it unchanged; never exceeds FIFO_DEPTH.
REQ-021 Per output: round-robin arbiter among inputs whose head flit is a head/single routed there; priority pointer moves to the input after the winner.
REQ-022 Wormhole lock per output: states IDLE, LOCKED(owner); IDLE->LOCKED on granting a head flit; LOCKED->IDLE on sending the owner's tail flit; single flit sends without locking.
REQ-023 While LOCKED, only the owner's body/tail flits go to that output; other requests wait.
REQ-024 Send requires credit counter > 0; if 0, the flit stays at FIFO head, no pop.
REQ-025 Latency: flit sampled at edge t appears on out_valid/out_data after edge t+2 when uncontended and credit available; throughput one flit/cycle/output.
REQ-026 Pop of input p produces in_credit[p] pulse after the following edge.
REQ-027 U-turn (output equals input port) is not routed; such a head flit is popped and dropped and its credit returned.
REQ-028 Body/tail flit reaching an input FIFO head with no active lock from that input is dropped with credit returned.

Reset
REQ-029 With rst low at an edge: FIFOs empty, locks IDLE, arbiter pointers 0, credits = FIFO_DEPTH, out_valid 0, out_data 0, in_credit 0, err_overflow 0.
REQ-030 Reset mid-packet discards all in-flight flits; no credit pulses issued for discarded flits.

Configuration
REQ-031 Macro NOC_ROUTER_WH_STATS_EN defined: adds output flit_cnt (5*16 bits), per-output count of sent flits, wraps 0xFFFF->0, cleared by reset.
REQ-032 Macro undefined: flit_cnt port and counters absent; all other behaviour identical.

Verification
REQ-033 Single flit 0xC0_21 (dX=1,dY=4) on L input -> N out_data 0xC021 exactly two edges later, in_credit[4] one pulse.
REQ-034 Head 0x400A (dX=2) on W, body 0x0055, tail 0x80AA -> E emits all three in order, one per cycle; E lock then IDLE.
REQ-035 Heads to E on N and S simultaneously, pointer 0 -> N packet fully sent first, S after N's tail; pointer then 2.
REQ-036 E credits exhausted (4 sends, no out_credit) -> 5th flit held; one out_credit pulse -> it is sent next cycle.
REQ-037 Five writes to N input with E blocked -> fifth write dropped, err_overflow[0]=1 until rst low.
REQ-038 rst low during LOCKED transfer -> next cycle all out_valid 0, credits 4, new head routes normally.

Source files
------------

// File: rtl/noc_router_wh.sv
// noc_router_wh: 5-port (N,S,E,W,L) wormhole mesh router, XY routing, credit-based flow control.
// Optional build macro NOC_ROUTER_WH_STATS_EN adds per-output sent-flit counters on flit_cnt.
module noc_router_wh #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned XCOORD     = 1,
  parameter int unsigned YCOORD     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_credit,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  input  logic [4:0]          out_credit,
  output logic [4:0]          err_overflow
`ifdef NOC_ROUTER_WH_STATS_EN
  ,
  output logic [5*16-1:0]     flit_cnt
`endif
);

  localparam int unsigned NP = 5;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] PortN = 3'd0;
  localparam logic [2:0] PortS = 3'd1;
  localparam logic [2:0] PortE = 3'd2;
  localparam logic [2:0] PortW = 3'd3;
  localparam logic [2:0] PortL = 3'd4;

  localparam logic [1:0] FtHead   = 2'b01;
  localparam logic [1:0] FtTail   = 2'b10;
  localparam logic [1:0] FtSingle = 2'b11;

  localparam logic [COORD_W-1:0] XC    = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] YC    = COORD_W'(YCOORD);
  localparam logic [CW-1:0]      Depth = CW'(FIFO_DEPTH);

  typedef enum logic {LkIdle, LkLocked} lock_e;

  function automatic logic [2:0] xy_route(input logic [2*COORD_W-1:0] coords);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = coords[COORD_W-1:0];
    dy = coords[2*COORD_W-1:COORD_W];
    if (dx > XC)      return PortE;
    else if (dx < XC) return PortW;
    else if (dy > YC) return PortN;
    else if (dy < YC) return PortS;
    else              return PortL;
  endfunction

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int unsigned k);
    int unsigned s;
    s = int'(base) + k;
    if (s >= NP) s = s - NP;
    return 3'(s);
  endfunction

  // Input capture stage
  logic [NP-1:0]     ireg_valid_q;
  logic [DATA_W-1:0] ireg_data_q [NP];

  // Input FIFOs
  logic [DATA_W-1:0] fifo_mem_q [NP][FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q [NP];
  logic [PW-1:0]     wr_ptr_q [NP];
  logic [CW-1:0]     cnt_q [NP];
  logic [CW-1:0]     cnt_d [NP];

  // Per-output state
  lock_e             lock_q [NP];
  lock_e             lock_d [NP];
  logic [2:0]        owner_q [NP];
  logic [2:0]        owner_d [NP];
  logic [2:0]        ptr_q [NP];
  logic [2:0]        ptr_d [NP];
  logic [CW-1:0]     credit_q [NP];
  logic [CW-1:0]     credit_d [NP];
  logic [CW:0]       credit_sum [NP];
  logic [DATA_W-1:0] out_data_q [NP];
  logic [DATA_W-1:0] out_data_d [NP];
  logic [NP-1:0]     out_valid_q;
  logic [NP-1:0]     in_credit_q;
  logic [NP-1:0]     ovf_q;

  // Head-of-FIFO decode
  logic [DATA_W-1:0] head_data [NP];
  logic [1:0]        head_type [NP];
  logic [2:0]        head_route [NP];
  logic [NP-1:0]     head_valid;
  logic [NP-1:0]     head_start;
  logic [NP-1:0]     owns_lock;
  logic [NP-1:0]     drop;
  logic [NP-1:0]     pop;
  logic [NP-1:0]     push;
  logic [NP-1:0]     full;
  logic [NP-1:0]     ovf_set;

  logic [NP-1:0]     gnt_valid;
  logic [2:0]        gnt_idx [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      head_data[i]  = fifo_mem_q[i][rd_ptr_q[i]];
      head_type[i]  = head_data[i][DATA_W-1 -: 2];
      head_route[i] = xy_route(head_data[i][2*COORD_W-1:0]);
      head_valid[i] = (cnt_q[i] != '0);
      head_start[i] = (head_type[i] == FtHead) || (head_type[i] == FtSingle);
      owns_lock[i]  = 1'b0;
      for (int o = 0; o < NP; o++) begin
        if (lock_q[o] == LkLocked && owner_q[o] == 3'(i)) owns_lock[i] = 1'b1;
      end
      // U-turn heads and orphaned body/tail flits are discarded but still return credit.
      drop[i] = head_valid[i] &&
                (head_start[i] ? (head_route[i] == 3'(i)) : !owns_lock[i]);
    end
  end

  // Arbitration: a locked output only serves its owner; an idle one round-robins over heads.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      gnt_valid[o] = 1'b0;
      gnt_idx[o]   = '0;
      if (credit_q[o] != '0) begin
        if (lock_q[o] == LkLocked) begin
          if (head_valid[owner_q[o]] && !head_start[owner_q[o]]) begin
            gnt_valid[o] = 1'b1;
            gnt_idx[o]   = owner_q[o];
          end
        end else begin
          for (int unsigned k = 0; k < NP; k++) begin
            if (!gnt_valid[o]
                && head_valid[rr_idx(ptr_q[o], k)]
                && head_start[rr_idx(ptr_q[o], k)]
                && head_route[rr_idx(ptr_q[o], k)] == 3'(o)
                && rr_idx(ptr_q[o], k) != 3'(o)) begin
              gnt_valid[o] = 1'b1;
              gnt_idx[o]   = rr_idx(ptr_q[o], k);
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pop[i] = drop[i];
      for (int o = 0; o < NP; o++) begin
        if (gnt_valid[o] && gnt_idx[o] == 3'(i)) pop[i] = 1'b1;
      end
      full[i]    = (cnt_q[i] == Depth);
      push[i]    = ireg_valid_q[i] && (!full[i] || pop[i]);
      ovf_set[i] = ireg_valid_q[i] && full[i] && !pop[i];
      cnt_d[i]   = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  // Wormhole lock FSM, arbiter pointer, credits and output register next state.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      lock_d[o]     = lock_q[o];
      owner_d[o]    = owner_q[o];
      ptr_d[o]      = ptr_q[o];
      out_data_d[o] = '0;
      if (gnt_valid[o]) begin
        out_data_d[o] = head_data[gnt_idx[o]];
        if (lock_q[o] == LkIdle) begin
          ptr_d[o] = (gnt_idx[o] == 3'(NP - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
          if (head_type[gnt_idx[o]] == FtHead) begin
            lock_d[o]  = LkLocked;
            owner_d[o] = gnt_idx[o];
          end
        end else if (head_type[gnt_idx[o]] == FtTail) begin
          lock_d[o] = LkIdle;
        end
      end
      credit_sum[o] = {1'b0, credit_q[o]} + (CW + 1)'(out_credit[o])
                      - (CW + 1)'(gnt_valid[o]);
      credit_d[o]   = (credit_sum[o] > {1'b0, Depth}) ? Depth : credit_sum[o][CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ireg_valid_q <= '0;
      out_valid_q  <= '0;
      in_credit_q  <= '0;
      ovf_q        <= '0;
      for (int i = 0; i < NP; i++) begin
        ireg_data_q[i] <= '0;
        rd_ptr_q[i]    <= '0;
        wr_ptr_q[i]    <= '0;
        cnt_q[i]       <= '0;
        lock_q[i]      <= LkIdle;
        owner_q[i]     <= '0;
        ptr_q[i]       <= '0;
        credit_q[i]    <= Depth;
        out_data_q[i]  <= '0;
      end
    end else begin
      ireg_valid_q <= in_valid;
      out_valid_q  <= gnt_valid;
      in_credit_q  <= pop;
      ovf_q        <= ovf_q | ovf_set;
      for (int i = 0; i < NP; i++) begin
        ireg_data_q[i] <= in_data[i*DATA_W +: DATA_W];
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        cnt_q[i]      <= cnt_d[i];
        lock_q[i]     <= lock_d[i];
        owner_q[i]    <= owner_d[i];
        ptr_q[i]      <= ptr_d[i];
        credit_q[i]   <= credit_d[i];
        out_data_q[i] <= out_data_d[i];
      end
    end
  end

  // Storage is not reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= ireg_data_q[i];
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) out_data[o*DATA_W +: DATA_W] = out_data_q[o];
  end

  assign out_valid    = out_valid_q;
  assign in_credit    = in_credit_q;
  assign err_overflow = ovf_q;

`ifdef NOC_ROUTER_WH_STATS_EN
  logic [15:0] sent_cnt_q [NP];

  always_ff @(posedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (!rst)              sent_cnt_q[o] <= '0;
      else if (gnt_valid[o]) sent_cnt_q[o] <= sent_cnt_q[o] + 16'd1;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) flit_cnt[o*16 +: 16] = sent_cnt_q[o];
  end
`endif

endmodule
